riscv_cpu: RTL and testbench

- Five-stage in-order pipelined RV32I-subset processor: IF, ID, EX, MEM, WB.
- Contains its own instruction memory, data memory and register file.
- Includes full forwarding, one-cycle load-use stall detection and branch flush.
- Top-level compute core; the only external pins are the clock and reset. Benches observe state through hierarchy: imem.IMem, dmem.DMem, regfile.Regs, if_stage.PC, and the pipeline buses if_id_bus_in, id_ex_bus_in, ex_mem_bus_in, mem_wb_bus_in, mem_wb_bus_out, ctrl_signals.

---
 rtl/riscv_cpu.sv | 365 ++++++++++++++++++++++++++++++++++++
 tb/tb_riscv_cpu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_cpu.sv
// Five-stage in-order RV32I-subset core: add/sub/and/or/slt, addi/andi/ori,
// lw/sw, beq/bne, with full forwarding, load-use stall and branch flush.
package riscv_pkg;
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    branch_ne;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instruction;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write, mem_read, mem_write;
        logic [4:0]  rd;
        logic [31:0] alu, wdata;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] result;
    } mem_wb_t;
endpackage

module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o
);
    logic [31:0] PC;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = PC + 32'd4;
        if (redirect_i)   pc_d = target_i;
        else if (stall_i) pc_d = PC;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) PC <= RESET_PC;
        else         PC <= pc_d;
    end

    assign pc_o = PC;
endmodule

module riscv_imem #(
    parameter int WORDS = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(WORDS)-1:0] waddr_i,
    input  logic [31:0]              wdata_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] IMem [WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) IMem[waddr_i] <= wdata_i;
    end

    assign rdata_o = IMem[addr_i];
endmodule

module riscv_dmem #(
    parameter int WORDS = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(WORDS)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);
    logic [31:0] DMem [WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) DMem[addr_i] <= wdata_i;
    end

    assign rdata_o = DMem[addr_i];
endmodule

module riscv_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] Regs [32];
    logic        wr;

    assign wr = we_i && (wa_i != 5'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) Regs[i] <= '0;
        end else if (wr) begin
            Regs[wa_i] <= wd_i;
        end
    end

    // Same-cycle WB write is bypassed so ID never sees a stale value
    always_comb begin
        rd1_o = Regs[ra1_i];
        rd2_o = Regs[ra2_i];
        if (wr && wa_i == ra1_i) rd1_o = wd_i;
        if (wr && wa_i == ra2_i) rd2_o = wd_i;
    end
endmodule

module riscv_cpu
    import riscv_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clock,
    input logic reset
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    if_id_t  if_id_bus_in,  if_id_bus_out;
    id_ex_t  id_ex_bus_in,  id_ex_bus_out;
    ex_mem_t ex_mem_bus_in, ex_mem_bus_out;
    mem_wb_t mem_wb_bus_in, mem_wb_bus_out;
    ctrl_t   ctrl_signals;

    logic [31:0] pc, instr, rd1, rd2, imm, dm_rdata;
    logic [31:0] br_target, op_a, op_b, fwd_b, alu_y;
    logic        stall, flush;

    riscv_fetch_stage #(.RESET_PC(RESET_PC)) if_stage (
        .clk_i(clock), .rst_ni(reset), .stall_i(stall),
        .redirect_i(flush), .target_i(br_target), .pc_o(pc)
    );

    riscv_imem #(.WORDS(IMEM_WORDS)) imem (
        .clk_i(clock), .we_i(1'b0), .waddr_i('0), .wdata_i('0),
        .addr_i(pc[IAW+1:2]), .rdata_o(instr)
    );

    always_comb begin
        if_id_bus_in = '0;
        if (!flush) begin
            if_id_bus_in.valid       = 1'b1;
            if_id_bus_in.pc          = pc;
            if_id_bus_in.instruction = instr;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)               if_id_bus_out <= '0;
        else if (flush || !stall) if_id_bus_out <= if_id_bus_in;
    end

    logic [31:0] ins;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b;
    logic        op_r, op_i, op_ld, op_st, op_br;

    assign ins   = if_id_bus_out.instruction;
    assign opc   = ins[6:0];
    assign f3    = ins[14:12];
    assign f7    = ins[31:25];
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};

    assign op_r  = opc == 7'b0110011;
    assign op_i  = opc == 7'b0010011;
    assign op_ld = opc == 7'b0000011 && f3 == 3'b010;
    assign op_st = opc == 7'b0100011 && f3 == 3'b010;
    assign op_br = opc == 7'b1100011 && f3[2:1] == 2'b00;

    logic    r_ok, i_ok;
    alu_op_e r_alu, i_alu;

    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        if (f7 == 7'b0 && f3 == 3'b000)              r_alu = ALU_ADD;
        else if (f7 == 7'b0100000 && f3 == 3'b000)   r_alu = ALU_SUB;
        else if (f7 == 7'b0 && f3 == 3'b111)         r_alu = ALU_AND;
        else if (f7 == 7'b0 && f3 == 3'b110)         r_alu = ALU_OR;
        else if (f7 == 7'b0 && f3 == 3'b010)         r_alu = ALU_SLT;
        else                                         r_ok  = 1'b0;
        i_ok  = 1'b1;
        i_alu = ALU_ADD;
        if (f3 == 3'b000)      i_alu = ALU_ADD;
        else if (f3 == 3'b111) i_alu = ALU_AND;
        else if (f3 == 3'b110) i_alu = ALU_OR;
        else                   i_ok  = 1'b0;
    end

    always_comb begin
        ctrl_signals = '0;
        imm          = '0;
        if (if_id_bus_out.valid) begin
            unique case (1'b1)
                op_r && r_ok: begin
                    ctrl_signals.reg_write = 1'b1;
                    ctrl_signals.alu_op    = r_alu;
                end
                op_i && i_ok: begin
                    ctrl_signals.reg_write = 1'b1;
                    ctrl_signals.alu_src   = 1'b1;
                    ctrl_signals.alu_op    = i_alu;
                    imm                    = imm_i;
                end
                op_ld: begin
                    ctrl_signals.reg_write = 1'b1;
                    ctrl_signals.mem_read  = 1'b1;
                    ctrl_signals.alu_src   = 1'b1;
                    imm                    = imm_i;
                end
                op_st: begin
                    ctrl_signals.mem_write = 1'b1;
                    ctrl_signals.alu_src   = 1'b1;
                    imm                    = imm_s;
                end
                op_br: begin
                    ctrl_signals.branch    = 1'b1;
                    ctrl_signals.branch_ne = f3[0];
                    imm                    = imm_b;
                end
                default: ;
            endcase
        end
    end

    riscv_regfile regfile (
        .clk_i(clock), .rst_ni(reset),
        .ra1_i(ins[19:15]), .ra2_i(ins[24:20]),
        .we_i(mem_wb_bus_out.valid && mem_wb_bus_out.reg_write),
        .wa_i(mem_wb_bus_out.rd), .wd_i(mem_wb_bus_out.result),
        .rd1_o(rd1), .rd2_o(rd2)
    );

    assign stall = id_ex_bus_out.ctrl.mem_read && id_ex_bus_out.rd != 5'd0
                && (id_ex_bus_out.rd == ins[19:15]
                 || id_ex_bus_out.rd == ins[24:20]);

    always_comb begin
        id_ex_bus_in = '0;
        if (!flush && !stall) begin
            id_ex_bus_in.valid = if_id_bus_out.valid;
            id_ex_bus_in.ctrl  = ctrl_signals;
            id_ex_bus_in.pc    = if_id_bus_out.pc;
            id_ex_bus_in.rs1   = ins[19:15];
            id_ex_bus_in.rs2   = ins[24:20];
            id_ex_bus_in.rd    = ins[11:7];
            id_ex_bus_in.rd1   = rd1;
            id_ex_bus_in.rd2   = rd2;
            id_ex_bus_in.imm   = imm;
        end
    end

    logic em_fwd, wb_fwd;
    assign em_fwd = ex_mem_bus_out.reg_write && !ex_mem_bus_out.mem_read
                 && ex_mem_bus_out.rd != 5'd0;
    assign wb_fwd = mem_wb_bus_out.reg_write && mem_wb_bus_out.rd != 5'd0;

    always_comb begin
        op_a = id_ex_bus_out.rd1;
        if (em_fwd && ex_mem_bus_out.rd == id_ex_bus_out.rs1)
            op_a = ex_mem_bus_out.alu;
        else if (wb_fwd && mem_wb_bus_out.rd == id_ex_bus_out.rs1)
            op_a = mem_wb_bus_out.result;
        fwd_b = id_ex_bus_out.rd2;
        if (em_fwd && ex_mem_bus_out.rd == id_ex_bus_out.rs2)
            fwd_b = ex_mem_bus_out.alu;
        else if (wb_fwd && mem_wb_bus_out.rd == id_ex_bus_out.rs2)
            fwd_b = mem_wb_bus_out.result;
        op_b = id_ex_bus_out.ctrl.alu_src ? id_ex_bus_out.imm : fwd_b;
    end

    always_comb begin
        case (id_ex_bus_out.ctrl.alu_op)
            ALU_SUB: alu_y = op_a - op_b;
            ALU_AND: alu_y = op_a & op_b;
            ALU_OR:  alu_y = op_a | op_b;
            ALU_SLT: alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
            default: alu_y = op_a + op_b;
        endcase
    end

    assign flush = id_ex_bus_out.valid && id_ex_bus_out.ctrl.branch
                && ((op_a == fwd_b) ^ id_ex_bus_out.ctrl.branch_ne);
    assign br_target = id_ex_bus_out.pc + id_ex_bus_out.imm;

    always_comb begin
        ex_mem_bus_in           = '0;
        ex_mem_bus_in.valid     = id_ex_bus_out.valid;
        ex_mem_bus_in.reg_write = id_ex_bus_out.ctrl.reg_write;
        ex_mem_bus_in.mem_read  = id_ex_bus_out.ctrl.mem_read;
        ex_mem_bus_in.mem_write = id_ex_bus_out.ctrl.mem_write;
        ex_mem_bus_in.rd        = id_ex_bus_out.rd;
        ex_mem_bus_in.alu       = alu_y;
        ex_mem_bus_in.wdata     = fwd_b;
    end

    riscv_dmem #(.WORDS(DMEM_WORDS)) dmem (
        .clk_i(clock),
        .we_i(ex_mem_bus_out.valid && ex_mem_bus_out.mem_write),
        .addr_i(ex_mem_bus_out.alu[DAW+1:2]),
        .wdata_i(ex_mem_bus_out.wdata), .rdata_o(dm_rdata)
    );

    always_comb begin
        mem_wb_bus_in           = '0;
        mem_wb_bus_in.valid     = ex_mem_bus_out.valid;
        mem_wb_bus_in.reg_write = ex_mem_bus_out.reg_write;
        mem_wb_bus_in.rd        = ex_mem_bus_out.rd;
        mem_wb_bus_in.result    = ex_mem_bus_out.mem_read ? dm_rdata
                                                          : ex_mem_bus_out.alu;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            id_ex_bus_out  <= '0;
            ex_mem_bus_out <= '0;
            mem_wb_bus_out <= '0;
        end else begin
            id_ex_bus_out  <= id_ex_bus_in;
            ex_mem_bus_out <= ex_mem_bus_in;
            mem_wb_bus_out <= mem_wb_bus_in;
        end
    end
endmodule

// File: tb/tb_riscv_cpu.sv
// Directed-program bench for riscv_cpu: loads small programs through
// hierarchy, runs a fixed number of cycles and checks architectural state.
module tb_riscv_cpu;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    riscv_cpu dut (
        .clock(clock),
        .reset(reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] sw_t(input logic [11:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_t(input logic [12:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
                7'b1100011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd,
        input logic [4:0] rs1, input logic [11:0] imm);
        return i_t(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd,
        input logic [4:0] rs1, input logic [11:0] imm);
        return i_t(imm, rs1, 3'b010, rd, 7'b0000011);
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 256; i++) begin
            dut.imem.IMem[i] <= 32'h0;
            dut.dmem.DMem[i] <= 32'h0;
        end
        @(negedge clock);
    endtask

    task automatic run(input int n);
        @(negedge clock);
        reset = 1'b1;
        repeat (n) step();
    endtask

    task automatic load_t1();
        dut.imem.IMem[0] <= addi(5'd1, 5'd0, 12'd5);
        dut.imem.IMem[1] <= addi(5'd2, 5'd0, 12'd3);
        dut.imem.IMem[2] <= r_t(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
    endtask

    logic [31:0] exp_r [13];
    logic [31:0] prev_pc;
    int          reps;
    logic        bub;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;

        hold_reset();
        chk("rst_pc", dut.if_stage.PC, 32'h0);
        chk("rst_ifid_v", {31'b0, dut.if_id_bus_out.valid}, 32'h0);
        chk("rst_idex_v", {31'b0, dut.id_ex_bus_out.valid}, 32'h0);

        load_t1();
        run(10);
        for (int i = 0; i < 13; i++) exp_r[i] = 32'h0;
        exp_r[1] = 32'd5;
        exp_r[2] = 32'd3;
        exp_r[3] = 32'd8;
        for (int i = 0; i <= 12; i++)
            chk($sformatf("fwd_x%0d", i), dut.regfile.Regs[i], exp_r[i]);

        hold_reset();
        dut.dmem.DMem[0] <= 32'd42;
        dut.imem.IMem[0] <= lw(5'd4, 5'd0, 12'd0);
        dut.imem.IMem[1] <= r_t(7'd0, 5'd4, 5'd4, 3'b000, 5'd5);
        @(negedge clock);
        reset   = 1'b1;
        prev_pc = 32'h0;
        reps    = 0;
        bub     = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (dut.if_stage.PC == prev_pc) reps++;
            if (k == 2) bub = dut.id_ex_bus_in.valid;
            prev_pc = dut.if_stage.PC;
        end
        chk("lu_repeats", reps, 32'd1);
        chk("lu_bubble", {31'b0, bub}, 32'h0);
        chk("lu_x4", dut.regfile.Regs[4], 32'd42);
        chk("lu_x5", dut.regfile.Regs[5], 32'd84);

        hold_reset();
        dut.imem.IMem[0] <= addi(5'd6, 5'd0, 12'd7);
        dut.imem.IMem[1] <= sw_t(12'd8, 5'd6, 5'd0);
        dut.imem.IMem[2] <= lw(5'd7, 5'd0, 12'd8);
        run(12);
        chk("st_dmem2", dut.dmem.DMem[2], 32'd7);
        chk("st_x7", dut.regfile.Regs[7], 32'd7);

        hold_reset();
        dut.imem.IMem[0] <= addi(5'd1, 5'd0, 12'd1);
        dut.imem.IMem[1] <= b_t(13'd8, 5'd1, 5'd1, 3'b000);
        dut.imem.IMem[2] <= addi(5'd8, 5'd0, 12'd9);
        dut.imem.IMem[3] <= addi(5'd9, 5'd0, 12'd4);
        run(4);
        chk("br_pc", dut.if_stage.PC, 32'd12);
        repeat (8) step();
        chk("br_x8", dut.regfile.Regs[8], 32'd0);
        chk("br_x9", dut.regfile.Regs[9], 32'd4);
        chk("br_x1", dut.regfile.Regs[1], 32'd1);

        hold_reset();
        dut.imem.IMem[0] <= addi(5'd0, 5'd0, 12'd5);
        dut.imem.IMem[1] <= r_t(7'd0, 5'd0, 5'd0, 3'b000, 5'd10);
        run(10);
        chk("x0_x0", dut.regfile.Regs[0], 32'd0);
        chk("x0_x10", dut.regfile.Regs[10], 32'd0);

        hold_reset();
        dut.imem.IMem[0]  <= addi(5'd1, 5'd0, 12'hFFD);
        dut.imem.IMem[1]  <= addi(5'd2, 5'd0, 12'd5);
        dut.imem.IMem[2]  <= r_t(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
        dut.imem.IMem[3]  <= r_t(7'd0, 5'd2, 5'd1, 3'b111, 5'd4);
        dut.imem.IMem[4]  <= r_t(7'd0, 5'd2, 5'd1, 3'b110, 5'd5);
        dut.imem.IMem[5]  <= r_t(7'd0, 5'd2, 5'd1, 3'b010, 5'd6);
        dut.imem.IMem[6]  <= r_t(7'd0, 5'd1, 5'd2, 3'b010, 5'd7);
        dut.imem.IMem[7]  <= i_t(12'd15, 5'd1, 3'b111, 5'd8, 7'b0010011);
        dut.imem.IMem[8]  <= i_t(12'd16, 5'd2, 3'b110, 5'd9, 7'b0010011);
        dut.imem.IMem[9]  <= b_t(13'd8, 5'd2, 5'd2, 3'b001);
        dut.imem.IMem[10] <= addi(5'd10, 5'd0, 12'd1);
        dut.imem.IMem[11] <= addi(5'd11, 5'd3, 12'd1);
        run(20);
        chk("alu_sub", dut.regfile.Regs[3], 32'hFFFF_FFF8);
        chk("alu_and", dut.regfile.Regs[4], 32'h0000_0005);
        chk("alu_or", dut.regfile.Regs[5], 32'hFFFF_FFFD);
        chk("alu_slt1", dut.regfile.Regs[6], 32'd1);
        chk("alu_slt0", dut.regfile.Regs[7], 32'd0);
        chk("alu_andi", dut.regfile.Regs[8], 32'h0000_000D);
        chk("alu_ori", dut.regfile.Regs[9], 32'h0000_0015);
        chk("bne_nt", dut.regfile.Regs[10], 32'd1);
        chk("alu_addi", dut.regfile.Regs[11], 32'hFFFF_FFF9);

        hold_reset();
        load_t1();
        run(6);
        chk("mid_pre_x1", dut.regfile.Regs[1], 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_pc", dut.if_stage.PC, 32'h0);
        chk("mid_x1", dut.regfile.Regs[1], 32'd0);
        chk("mid_idex_v", {31'b0, dut.id_ex_bus_out.valid}, 32'h0);
        run(10);
        chk("mid_re_x3", dut.regfile.Regs[3], 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
